// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between rendering fetches and a
// one-entry buffered CPU ($2007) access path.
//   clk, reset_n                  : clock, async active-low reset
//   rendering_en, render_req/addr : render fetch request; render_gnt is the
//                                   combinational grant for this cycle
//   render_rvalid                 : vram_rdata holds the granted fetch's data
//   cpu_rd_req/cpu_wr_req/addr/wdata : single-cycle CPU access pulses
//   cpu_busy, cpu_done, cpu_rdata, cpu_overrun : CPU buffer status/results
//   vram_addr/we/wdata (registered), vram_rdata (one-cycle read latency)
module vram_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   localparam int unsigned AW  = 14,
   localparam int unsigned DW  = 8,
   localparam int unsigned VAW = 16,
   localparam int unsigned WW  = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           rendering_en,
   input  logic           render_req,
   input  logic [AW-1:0]  render_addr,
   output logic           render_gnt,
   output logic           render_rvalid,
   input  logic           cpu_rd_req,
   input  logic           cpu_wr_req,
   input  logic [AW-1:0]  cpu_addr,
   input  logic [DW-1:0]  cpu_wdata,
   output logic           cpu_busy,
   output logic           cpu_done,
   output logic [DW-1:0]  cpu_rdata,
   output logic           cpu_overrun,
   output logic [VAW-1:0] vram_addr,
   output logic           vram_we,
   output logic [DW-1:0]  vram_wdata,
   input  logic [DW-1:0]  vram_rdata
);

   // Last issue type; feeds the rvalid/done pipeline one cycle later.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RENDER = 2'd1,
      S_CPU_RD = 2'd2,
      S_CPU_WR = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             buf_valid_q, buf_valid_d;
   logic             buf_wr_q, buf_wr_d;
   logic [AW-1:0]    buf_addr_q, buf_addr_d;
   logic [DW-1:0]    buf_data_q, buf_data_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic             rd_p2_q, rd_p2_d;
   logic             render_rvalid_q, render_rvalid_d;
   logic             cpu_done_q, cpu_done_d;
   logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic             cpu_overrun_q, cpu_overrun_d;
   logic [VAW-1:0]   vram_addr_q, vram_addr_d;
   logic             vram_we_q, vram_we_d;
   logic [DW-1:0]    vram_wdata_q, vram_wdata_d;

   logic             cpu_force_c;
   logic             render_win_c;
   logic             cpu_win_c;
   logic             cpu_req_c;
   logic             cpu_accept_c;

   // Arbitration: a starved CPU access beats rendering, rendering beats a fresh one.
   assign cpu_force_c  = buf_valid_q && (wait_cnt_q == WW'(MAX_WAIT));
   assign render_win_c = rendering_en && render_req && !cpu_force_c;
   assign cpu_win_c    = buf_valid_q && !render_win_c;

   // Exactly one request type and an empty buffer; anything else is an overrun.
   assign cpu_req_c    = cpu_rd_req || cpu_wr_req;
   assign cpu_accept_c = (cpu_rd_req ^ cpu_wr_req) && !buf_valid_q;

   // Grant is gated by reset so it reads 0 while reset_n is low.
   assign render_gnt    = reset_n && render_win_c;
   assign render_rvalid = render_rvalid_q;
   assign cpu_busy      = buf_valid_q;
   assign cpu_done      = cpu_done_q;
   assign cpu_rdata     = cpu_rdata_q;
   assign cpu_overrun   = cpu_overrun_q;
   assign vram_addr     = vram_addr_q;
   assign vram_we       = vram_we_q;
   assign vram_wdata    = vram_wdata_q;

   // Next-state and registered-output logic.
   always_comb begin
      state_d         = S_IDLE;
      buf_valid_d     = buf_valid_q;
      buf_wr_d        = buf_wr_q;
      buf_addr_d      = buf_addr_q;
      buf_data_d      = buf_data_q;
      wait_cnt_d      = wait_cnt_q;
      cpu_overrun_d   = cpu_overrun_q;
      vram_addr_d     = vram_addr_q;
      vram_we_d       = 1'b0;
      vram_wdata_d    = vram_wdata_q;
      cpu_rdata_d     = cpu_rdata_q;
      render_rvalid_d = (state_q == S_RENDER);
      rd_p2_d         = (state_q == S_CPU_RD);
      cpu_done_d      = rd_p2_q || (state_q == S_CPU_WR);

      // Read data arrives two cycles after issue; capture it then.
      if (rd_p2_q) begin
         cpu_rdata_d = vram_rdata;
      end

      if (render_win_c) begin
         state_d     = S_RENDER;
         vram_addr_d = {2'b00, render_addr};
         if (buf_valid_q && (wait_cnt_q < WW'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
         end
      end else if (cpu_win_c) begin
         state_d     = buf_wr_q ? S_CPU_WR : S_CPU_RD;
         vram_addr_d = {2'b00, buf_addr_q};
         vram_we_d   = buf_wr_q;
         if (buf_wr_q) begin
            vram_wdata_d = buf_data_q;
         end
         buf_valid_d = 1'b0;
         wait_cnt_d  = '0;
      end

      // Accept only into an empty buffer, so it never collides with an issue.
      if (cpu_accept_c) begin
         buf_valid_d = 1'b1;
         buf_wr_d    = cpu_wr_req;
         buf_addr_d  = cpu_addr;
         buf_data_d  = cpu_wdata;
      end else if (cpu_req_c) begin
         cpu_overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         buf_valid_q     <= 1'b0;
         buf_wr_q        <= 1'b0;
         buf_addr_q      <= '0;
         buf_data_q      <= '0;
         wait_cnt_q      <= '0;
         rd_p2_q         <= 1'b0;
         render_rvalid_q <= 1'b0;
         cpu_done_q      <= 1'b0;
         cpu_rdata_q     <= '0;
         cpu_overrun_q   <= 1'b0;
         vram_addr_q     <= '0;
         vram_we_q       <= 1'b0;
         vram_wdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         buf_valid_q     <= buf_valid_d;
         buf_wr_q        <= buf_wr_d;
         buf_addr_q      <= buf_addr_d;
         buf_data_q      <= buf_data_d;
         wait_cnt_q      <= wait_cnt_d;
         rd_p2_q         <= rd_p2_d;
         render_rvalid_q <= render_rvalid_d;
         cpu_done_q      <= cpu_done_d;
         cpu_rdata_q     <= cpu_rdata_d;
         cpu_overrun_q   <= cpu_overrun_d;
         vram_addr_q     <= vram_addr_d;
         vram_we_q       <= vram_we_d;
         vram_wdata_q    <= vram_wdata_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: per-cycle vector table with expected outputs,
// a scoreboard for render read data and CPU completions, and hand-written
// reset and overrun sequences.
module tb_vram_arbiter;
   localparam int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rendering_en;
   logic        render_req;
   logic [13:0] render_addr;
   logic        render_gnt;
   logic        render_rvalid;
   logic        cpu_rd_req;
   logic        cpu_wr_req;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic [7:0]  cpu_rdata;
   logic        cpu_overrun;
   logic [15:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata = 8'h00;

   vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .rendering_en(rendering_en), .render_req(render_req),
      .render_addr(render_addr), .render_gnt(render_gnt),
      .render_rvalid(render_rvalid),
      .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_done(cpu_done),
      .cpu_rdata(cpu_rdata), .cpu_overrun(cpu_overrun),
      .vram_addr(vram_addr), .vram_we(vram_we),
      .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
   );

   always #5 clk = ~clk;

   // VRAM model: synchronous write, read data one cycle after the address.
   logic [7:0] mem     [0:16383];
   logic [7:0] ref_mem [0:16383];
   always @(posedge clk) begin
      if (vram_we) mem[vram_addr[13:0]] <= vram_wdata;
      vram_rdata <= mem[vram_addr[13:0]];
   end

   function automatic logic [7:0] fpat(input logic [13:0] a);
      return a[7:0] ^ 8'h5A ^ {2'b00, a[13:8]};
   endfunction

   // flags = {gnt, busy, we, rvalid, done, overrun}
   typedef struct {
      logic        re, rr;
      logic [13:0] raddr;
      logic        crd, cwr;
      logic [13:0] caddr;
      logic [7:0]  cwd;
      logic        acc;
      logic [5:0]  flags;
      logic [15:0] vaddr;
      logic [7:0]  wdata, rdata;
   } vec_t;

   typedef struct {
      logic       is_rd;
      logic [7:0] data;
   } cpu_exp_t;

   vec_t       vecs[$];
   logic [7:0] rnd_q[$];
   cpu_exp_t   cpu_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic void add(input logic re, input logic rr, input logic [13:0] raddr,
                               input logic crd, input logic cwr, input logic [13:0] caddr,
                               input logic [7:0] cwd, input logic acc, input logic [5:0] flags,
                               input logic [15:0] vaddr, input logic [7:0] wdata,
                               input logic [7:0] rdata);
      vec_t v;
      v.re = re; v.rr = rr; v.raddr = raddr; v.crd = crd; v.cwr = cwr;
      v.caddr = caddr; v.cwd = cwd; v.acc = acc; v.flags = flags;
      v.vaddr = vaddr; v.wdata = wdata; v.rdata = rdata;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] f11, f300;
      f11  = fpat(14'h0011);
      f300 = fpat(14'h0300);
      //   re rr raddr     crd cwr caddr     cwd    acc flags      vaddr     wdata  rdata
      // CPU write 0x2005 <= 0x3C with rendering off (render_req ignored)
      add(0, 0, 14'h0000, 0, 1, 14'h2005, 8'h3C, 1, 6'b000000, 16'h0000, 8'h00, 8'h00); // 0
      add(0, 1, 14'h0123, 0, 0, 14'h0000, 8'h00, 0, 6'b010000, 16'h0000, 8'h00, 8'h00); // 1
      add(0, 1, 14'h0123, 0, 0, 14'h0000, 8'h00, 0, 6'b001000, 16'h2005, 8'h3C, 8'h00); // 2
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000010, 16'h2005, 8'h3C, 8'h00); // 3
      // CPU read 0x0010 (0xA7)
      add(0, 0, 14'h0000, 1, 0, 14'h0010, 8'h00, 1, 6'b000000, 16'h2005, 8'h3C, 8'h00); // 4
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b010000, 16'h2005, 8'h3C, 8'h00); // 5
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000000, 16'h0010, 8'h3C, 8'h00); // 6
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000000, 16'h0010, 8'h3C, 8'h00); // 7
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000010, 16'h0010, 8'h3C, 8'hA7); // 8
      // Continuous rendering starves a CPU read until wait reaches MAX_WAIT
      add(1, 1, 14'h0100, 1, 0, 14'h0011, 8'h00, 1, 6'b100000, 16'h0010, 8'h3C, 8'hA7); // 9
      add(1, 1, 14'h0101, 0, 0, 14'h0000, 8'h00, 0, 6'b110000, 16'h0100, 8'h3C, 8'hA7); // 10
      add(1, 1, 14'h0102, 0, 0, 14'h0000, 8'h00, 0, 6'b110100, 16'h0101, 8'h3C, 8'hA7); // 11
      add(1, 1, 14'h0103, 0, 0, 14'h0000, 8'h00, 0, 6'b110100, 16'h0102, 8'h3C, 8'hA7); // 12
      add(1, 1, 14'h0104, 0, 0, 14'h0000, 8'h00, 0, 6'b110100, 16'h0103, 8'h3C, 8'hA7); // 13
      add(1, 1, 14'h0105, 0, 0, 14'h0000, 8'h00, 0, 6'b010100, 16'h0104, 8'h3C, 8'hA7); // 14
      add(1, 1, 14'h0106, 0, 0, 14'h0000, 8'h00, 0, 6'b100100, 16'h0011, 8'h3C, 8'hA7); // 15
      add(1, 1, 14'h0107, 0, 0, 14'h0000, 8'h00, 0, 6'b100000, 16'h0106, 8'h3C, 8'hA7); // 16
      add(1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000110, 16'h0107, 8'h3C, f11);   // 17
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000100, 16'h0107, 8'h3C, f11);   // 18
      // Second write while busy is dropped and sets overrun
      add(0, 0, 14'h0000, 0, 1, 14'h0200, 8'h11, 1, 6'b000000, 16'h0107, 8'h3C, f11);   // 19
      add(0, 0, 14'h0000, 0, 1, 14'h0300, 8'h22, 0, 6'b010000, 16'h0107, 8'h3C, f11);   // 20
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b001001, 16'h0200, 8'h11, f11);   // 21
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000011, 16'h0200, 8'h11, f11);   // 22
      // Alternating render / CPU wins, one access per cycle
      add(1, 1, 14'h0400, 1, 0, 14'h2005, 8'h00, 1, 6'b100001, 16'h0200, 8'h11, f11);   // 23
      add(1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b010001, 16'h0400, 8'h11, f11);   // 24
      add(1, 1, 14'h0401, 0, 1, 14'h0500, 8'h77, 1, 6'b100101, 16'h2005, 8'h11, f11);   // 25
      add(1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b010001, 16'h0401, 8'h11, f11);   // 26
      add(1, 1, 14'h0402, 1, 0, 14'h0300, 8'h00, 1, 6'b101111, 16'h0500, 8'h77, 8'h3C); // 27
      add(1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b010011, 16'h0402, 8'h77, 8'h3C); // 28
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000101, 16'h0300, 8'h77, 8'h3C); // 29
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000001, 16'h0300, 8'h77, 8'h3C); // 30
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000011, 16'h0300, 8'h77, f300);  // 31
      add(0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 6'b000001, 16'h0300, 8'h77, f300);  // 32

      for (int a = 0; a < 16384; a++) begin
         mem[a]     = fpat(14'(a));
         ref_mem[a] = fpat(14'(a));
      end
      mem[14'h0010]     = 8'hA7;
      ref_mem[14'h0010] = 8'hA7;

      reset_n = 1'b0;
      rendering_en = 1'b1; render_req = 1'b1; render_addr = 14'h0055;
      cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", render_gnt, 0);
      chk("rst_rvalid", render_rvalid, 0);
      chk("rst_busy", cpu_busy, 0);
      chk("rst_done", cpu_done, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_overrun", cpu_overrun, 0);
      chk("rst_vaddr", vram_addr, 0);
      chk("rst_we", vram_we, 0);
      chk("rst_wdata", vram_wdata, 0);
      rendering_en = 1'b0; render_req = 1'b0; render_addr = '0;
      @(negedge clk) reset_n = 1'b1;

      foreach (vecs[i]) begin
         vec_t     v;
         cpu_exp_t ce;
         v = vecs[i];
         @(posedge clk);
         #1;
         rendering_en = v.re; render_req = v.rr; render_addr = v.raddr;
         cpu_rd_req = v.crd; cpu_wr_req = v.cwr; cpu_addr = v.caddr; cpu_wdata = v.cwd;
         if (v.acc) begin
            ce.is_rd = v.crd;
            ce.data  = v.crd ? ref_mem[v.caddr] : 8'h00;
            if (v.cwr) ref_mem[v.caddr] = v.cwd;
            cpu_q.push_back(ce);
         end
         if (v.flags[5]) rnd_q.push_back(ref_mem[v.raddr]);
         @(negedge clk);
         chk($sformatf("r%0d_gnt", i),      render_gnt,    v.flags[5]);
         chk($sformatf("r%0d_busy", i),     cpu_busy,      v.flags[4]);
         chk($sformatf("r%0d_we", i),       vram_we,       v.flags[3]);
         chk($sformatf("r%0d_rvalid", i),   render_rvalid, v.flags[2]);
         chk($sformatf("r%0d_done", i),     cpu_done,      v.flags[1]);
         chk($sformatf("r%0d_overrun", i),  cpu_overrun,   v.flags[0]);
         chk($sformatf("r%0d_vaddr", i),    vram_addr,     v.vaddr);
         chk($sformatf("r%0d_wdata", i),    vram_wdata,    v.wdata);
         chk($sformatf("r%0d_rdata", i),    cpu_rdata,     v.rdata);
         if (render_rvalid) begin
            if (rnd_q.size() == 0) chk($sformatf("r%0d_rvalid_unexpected", i), 1, 0);
            else chk($sformatf("r%0d_render_data", i), vram_rdata, rnd_q.pop_front());
         end
         if (cpu_done) begin
            if (cpu_q.size() == 0) chk($sformatf("r%0d_done_unexpected", i), 1, 0);
            else begin
               ce = cpu_q.pop_front();
               if (ce.is_rd) chk($sformatf("r%0d_done_rdata", i), cpu_rdata, ce.data);
            end
         end
      end
      chk("render_q_drained", rnd_q.size(), 0);
      chk("cpu_q_drained", cpu_q.size(), 0);

      // Reset in the cycle after a render grant discards the fetch.
      @(posedge clk);
      #1;
      rendering_en = 1'b1; render_req = 1'b1; render_addr = 14'h0600;
      cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
      @(negedge clk);
      chk("h1_gnt", render_gnt, 1);
      @(posedge clk);
      #1;
      chk("h1_vaddr", vram_addr, 16'h0600);
      #2 reset_n = 1'b0;
      #1;
      chk("h1_rst_gnt", render_gnt, 0);
      chk("h1_rst_vaddr", vram_addr, 0);
      chk("h1_rst_wdata", vram_wdata, 0);
      chk("h1_rst_rdata", cpu_rdata, 0);
      chk("h1_rst_overrun", cpu_overrun, 0);
      chk("h1_rst_rvalid", render_rvalid, 0);
      @(negedge clk);
      rendering_en = 1'b0; render_req = 1'b0;
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("h1_post_rvalid%0d", k), render_rvalid, 0);
         chk($sformatf("h1_post_done%0d", k), cpu_done, 0);
      end

      // Simultaneous read and write: dropped, overrun set, buffer stays empty.
      @(posedge clk);
      #1;
      cpu_rd_req = 1'b1; cpu_wr_req = 1'b1; cpu_addr = 14'h0700; cpu_wdata = 8'h99;
      @(posedge clk);
      #1;
      cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
      @(negedge clk);
      chk("h2_busy", cpu_busy, 0);
      chk("h2_overrun", cpu_overrun, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("h2_we%0d", k), vram_we, 0);
         chk($sformatf("h2_done%0d", k), cpu_done, 0);
         chk($sformatf("h2_overrun_hold%0d", k), cpu_overrun, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
